// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the serial 1-bit accumulator.
// Provides the default count width, the default count type and the
// bundle of raw strobe-domain inputs that crosses into the clk domain.
`timescale 1ns/1ps

package acc_pkg;

   // Default width of the accepted-ones counter.
   localparam int ACC_DEFAULT_WIDTH = 4;

   // Count value at the default width.
   typedef logic [ACC_DEFAULT_WIDTH-1:0] acc_count_t;

   // Raw strobe-side inputs, synchronized together so that the data bit
   // seen with a strobe edge is the one that travelled alongside it.
   typedef struct packed {
      logic a;
      logic iclk;
   } acc_samp_t;

   // Reset value of a synchronizer stage.
   localparam acc_samp_t ACC_SAMP_RST = '{a: 1'b0, iclk: 1'b0};

endpackage : acc_pkg

// File: rtl/acc_edge_sync.sv
// acc_edge_sync: two-flop synchronizer for {a, iclk} plus a rising-edge
// detector on the synchronized strobe.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset; clears every stage
//   a_i      in   raw data bit, asynchronous to clk
//   iclk_i   in   raw accumulate strobe, asynchronous to clk
//   strobe_o out  one-cycle pulse on each rising edge of the strobe
//   data_o   out  data bit aligned with strobe_o
`timescale 1ns/1ps

module acc_edge_sync
   import acc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a_i,
   input  logic iclk_i,
   output logic strobe_o,
   output logic data_o
);

   acc_samp_t s1_q;
   acc_samp_t s2_q;
   logic      s3_q;

   // s1/s2 form the metastability chain; s3 remembers the previous
   // settled strobe level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= ACC_SAMP_RST;
         s2_q <= ACC_SAMP_RST;
         s3_q <= 1'b0;
      end else begin
         s1_q <= '{a: a_i, iclk: iclk_i};
         s2_q <= s1_q;
         s3_q <= s2_q.iclk;
      end
   end

   // Rising edge only; a held-high strobe yields a single pulse and the
   // falling edge is ignored.
   assign strobe_o = s2_q.iclk & ~s3_q;
   assign data_o   = s2_q.a;

endmodule : acc_edge_sync

// File: rtl/accumulator.sv
// accumulator: serial 1-bit accumulator. Counts a=1 samples taken on
// rising edges of the asynchronous strobe iclk and reports their parity.
//
// Parameters:
//   WIDTH  count register width (>= 2), default ACC_DEFAULT_WIDTH
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   a      in   data bit, synchronized alongside iclk
//   iclk   in   accumulate strobe, asynchronous to clk
//   y      out  parity of accepted ones (registered)
//   count  out  accepted ones, modulo 2**WIDTH (registered)
//   wrap   out  one-cycle pulse when count rolls over to zero
// Build option:
//   SATURATE_EN  count sticks at all-ones, y keeps toggling, wrap is 0
`timescale 1ns/1ps

module accumulator
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             iclk,
   output logic             y,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             strobe;
   logic             data;
   logic             inc;
   logic             at_max;

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             y_q;
   logic             y_d;
   logic             wrap_q;
   logic             wrap_d;

   acc_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .a_i      (a),
      .iclk_i   (iclk),
      .strobe_o (strobe),
      .data_o   (data)
   );

   assign inc    = strobe & data;
   assign at_max = &count_q;

   always_comb begin
      count_d = count_q;
      y_d     = y_q;
      wrap_d  = 1'b0;
      if (inc) begin
         y_d = ~y_q;
`ifdef SATURATE_EN
         // Hold at all-ones; y carries the true parity from here on.
         if (!at_max) begin
            count_d = count_q + ONE;
         end
`else
         count_d = count_q + ONE;
         wrap_d  = at_max;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         y_q     <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         y_q     <= y_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign y     = y_q;
`ifdef SATURATE_EN
   assign wrap  = 1'b0;
`else
   assign wrap  = wrap_q;
`endif

endmodule : accumulator

// File: tb/tb_accumulator.sv
// tb_accumulator: scoreboard bench for the serial accumulator.
// Stimulus pushes expected outputs; a monitor checks each output change.
`timescale 1ns/1ps

module tb_accumulator;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       a    = 1'b0;
   logic       iclk = 1'b0;
   logic       y;
   logic [3:0] count;
   logic       wrap;

   accumulator #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .iclk  (iclk),
      .y     (y),
      .count (count),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       y;
      logic [3:0] cnt;
      logic       wr;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       e_m;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         wrap_hi = 0;
   bit         mon_en  = 1'b0;
   logic       m_y     = 1'b0;
   logic [3:0] m_cnt   = 4'd0;
   logic [4:0] prev    = 5'd0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change of {y,count} must match the next expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wrap === 1'b1) wrap_hi++;
         if ({y, count} !== prev) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: got y=%0d count=%0d, required y=%0d count=%0d",
                        y, count, prev[4], prev[3:0]);
            end else begin
               e_m = q.pop_front();
               if (y !== e_m.y || count !== e_m.cnt || wrap !== e_m.wr ||
                   (e_m.cyc >= 0 && cyc != e_m.cyc)) begin
                  n_fail++;
                  $display("FAIL update: got y=%0d count=%0d wrap=%0d cyc=%0d, required y=%0d count=%0d wrap=%0d cyc=%0d",
                           y, count, wrap, cyc, e_m.y, e_m.cnt, e_m.wr, e_m.cyc);
               end
            end
            prev = {y, count};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [5:0] got,
                        input logic [5:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   // One strobe pulse: high 3 cycles, low 3 cycles.
   task automatic pulse(input logic v);
      logic w;
      a    = v;
      iclk = 1'b1;
      if (v) begin
`ifdef SATURATE_EN
         w = 1'b0;
         if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
`else
         w     = (m_cnt == 4'hF);
         m_cnt = m_cnt + 4'd1;
`endif
         m_y = ~m_y;
         // Sampled at the next edge, visible two edges after that.
         q.push_back('{y: m_y, cnt: m_cnt, wr: w, cyc: cyc + 3});
      end
      tick(3);
      iclk = 1'b0;
      tick(3);
   endtask

   task automatic push_reset();
      if (m_y != 1'b0 || m_cnt != 4'd0)
         q.push_back('{y: 1'b0, cnt: 4'd0, wr: 1'b0, cyc: -1});
      m_y   = 1'b0;
      m_cnt = 4'd0;
   endtask

   task automatic do_reset();
      push_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   initial begin
      // 1: reset, then idle.
      #12 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle", {wrap, y, count}, 6'd0);
      end
      #1;
      mon_en = 1'b1;

      // 2: single a=1 pulse, then stable.
      pulse(1'b1);
      tick(10);
      check("single", {wrap, y, count}, {1'b0, 1'b1, 4'd1});

      // 3: three pulses from a clean state.
      do_reset();
      pulse(1'b1);
      pulse(1'b1);
      pulse(1'b1);
      check("three", {wrap, y, count}, {1'b0, 1'b1, 4'd3});

      // 4: a=0 pulses, then a toggling with iclk stable low and high.
      pulse(1'b0);
      pulse(1'b0);
      for (int i = 0; i < 6; i++) begin
         a = ~a;
         tick(2);
      end
      a    = 1'b0;
      iclk = 1'b1;
      tick(3);
      for (int i = 0; i < 6; i++) begin
         a = ~a;
         tick(2);
      end
      iclk = 1'b0;
      a    = 1'b0;
      tick(4);
      check("no_change", {wrap, y, count}, {1'b0, 1'b1, 4'd3});

      // 5: sixteen ones from zero.
      do_reset();
      wrap_hi = 0;
      for (int i = 0; i < 16; i++) pulse(1'b1);
      tick(4);
`ifdef SATURATE_EN
      check("sat_end", {wrap, y, count}, {1'b0, 1'b0, 4'd15});
      check("sat_wrap", 6'(wrap_hi), 6'd0);
`else
      check("wrap_end", {wrap, y, count}, {1'b0, 1'b0, 4'd0});
      check("wrap_once", 6'(wrap_hi), 6'd1);
`endif

      // 6: reset lands between strobe sample and update.
      pulse(1'b1);
      a    = 1'b1;
      iclk = 1'b1;
      tick(1);
      push_reset();
      rst  = 1'b1;
      iclk = 1'b0;
      tick(3);
      rst  = 1'b0;
      tick(10);
      check("rst_drop", {wrap, y, count}, 6'd0);

      for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
      while (q.size() != 0) begin
         e_m = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_update: got none, required y=%0d count=%0d",
                  e_m.y, e_m.cnt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_accumulator
